// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture engine.
package adc_capture_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } capture_state_e;

    localparam int unsigned BEAT_HALF_W = 128;

    // Bit positions of the fields inside the status word
    localparam int unsigned STATUS_INDEX_LSB   = 24;
    localparam int unsigned STATUS_INDEX_W     = 8;
    localparam int unsigned STATUS_CMD_ERR_BIT = 18;
    localparam int unsigned STATUS_OVF_BIT     = 17;
    localparam int unsigned STATUS_BUSY_BIT    = 16;
    localparam int unsigned STATUS_COUNT_LSB   = 0;
    localparam int unsigned STATUS_COUNT_W     = 16;

endpackage

// File: rtl/adc_capture_core_capture_buffer.sv
// Simple dual-port beat buffer with a registered read port; maps onto block RAM.
module capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * BEAT_HALF_W,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/adc_capture_core.sv
// Timestamped ADC capture: arms on a command, buffers N stream beats, and
// returns them as 128-bit words (low half first) through a pop interface.
module adc_capture_core
    import adc_capture_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 256,
    parameter int unsigned DEPTH_LOG2      = 10,
    parameter int unsigned INDEX           = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [63:0]                counter,
    input  logic [AXIS_DATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic                       cmd_valid,
    input  logic [15:0]                cmd_len,
    input  logic                       flush,
    input  logic                       rd_en,
    output logic [BEAT_HALF_W-1:0]     rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic [DEPTH_LOG2:0]        count,
    output logic                       busy,
    output logic                       capture_done,
    output logic [63:0]                capture_timestamp,
    output logic                       overflow_error,
    output logic                       cmd_error,
    output logic [31:0]                status
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(1) << DEPTH_LOG2;

    capture_state_e          state;
    logic [15:0]             remaining;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic                    half;
    logic                    rd_sel;
    logic                    rd_primed;
    logic [AXIS_DATA_WIDTH-1:0] ram_q;

    logic                    beat_c;
    logic                    cap_beat_c;
    logic                    full_c;
    logic                    do_write_c;
    logic                    do_pop_c;
    logic                    do_free_c;
    logic [CNT_W-1:0]        count_next_c;

    // Full/empty decisions use the occupancy at the start of the cycle
    always_comb begin
        beat_c       = s00_axis_tvalid && s00_axis_tready;
        cap_beat_c   = (state == CAPTURE) && beat_c;
        full_c       = (count == FULL_LEVEL);
        do_write_c   = cap_beat_c && !full_c && !flush;
        do_pop_c     = rd_en && (count != '0) && !flush;
        do_free_c    = do_pop_c && half;
        count_next_c = count;
        if (flush) begin
            count_next_c = '0;
        end else if (do_write_c && !do_free_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (!do_write_c && do_free_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            remaining         <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            half              <= 1'b0;
            rd_sel            <= 1'b0;
            rd_primed         <= 1'b0;
            count             <= '0;
            empty             <= 1'b1;
            rd_valid          <= 1'b0;
            capture_done      <= 1'b0;
            capture_timestamp <= '0;
            overflow_error    <= 1'b0;
            cmd_error         <= 1'b0;
            s00_axis_tready   <= 1'b0;
        end else begin
            s00_axis_tready <= 1'b1;
            capture_done    <= 1'b0;
            rd_valid        <= do_pop_c;
            count           <= count_next_c;
            empty           <= (count_next_c == '0);
            if (do_pop_c) begin
                rd_sel    <= half;
                rd_primed <= 1'b1;
            end
            if (flush) begin
                state          <= IDLE;
                remaining      <= '0;
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                half           <= 1'b0;
                overflow_error <= 1'b0;
                cmd_error      <= 1'b0;
            end else begin
                if (do_write_c) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (do_pop_c) begin
                    half <= ~half;
                end
                if (do_free_c) begin
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                end
                case (state)
                    IDLE: begin
                        if (cmd_valid && (cmd_len != 16'd0)) begin
                            state             <= CAPTURE;
                            capture_timestamp <= counter;
                            remaining         <= cmd_len;
                        end
                    end
                    CAPTURE: begin
                        if (cmd_valid) begin
                            cmd_error <= 1'b1;
                        end
                        // Dropped beats still consume the programmed length
                        if (cap_beat_c) begin
                            if (full_c) begin
                                overflow_error <= 1'b1;
                            end
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                state        <= IDLE;
                                capture_done <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    capture_buffer #(
        .DATA_W (AXIS_DATA_WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (do_write_c),
        .wr_addr (wr_ptr),
        .wr_data (s00_axis_tdata),
        .rd_en   (do_pop_c),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // RAM output register has no reset; hold the word at zero until the first pop
    always_comb begin
        rd_data = '0;
        if (rd_primed) begin
            rd_data = rd_sel ? ram_q[AXIS_DATA_WIDTH-1:BEAT_HALF_W] : ram_q[BEAT_HALF_W-1:0];
        end
    end

    assign busy = (state == CAPTURE);

    always_comb begin
        status = '0;
        status[STATUS_INDEX_LSB +: STATUS_INDEX_W] = STATUS_INDEX_W'(INDEX);
        status[STATUS_CMD_ERR_BIT]                 = cmd_error;
        status[STATUS_OVF_BIT]                     = overflow_error;
        status[STATUS_BUSY_BIT]                    = busy;
        status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(count);
    end

endmodule

// File: tb/tb_adc_capture_core.sv
// Directed bench for adc_capture_core with a word scoreboard (4-entry buffer).
module tb_adc_capture_core;

    localparam int unsigned DL2 = 2;

    logic          clk;
    logic          reset;
    logic [63:0]   counter;
    logic [255:0]  s00_axis_tdata;
    logic          s00_axis_tvalid;
    logic          s00_axis_tready;
    logic          cmd_valid;
    logic [15:0]   cmd_len;
    logic          flush;
    logic          rd_en;
    logic [127:0]  rd_data;
    logic          rd_valid;
    logic          empty;
    logic [DL2:0]  count;
    logic          busy;
    logic          capture_done;
    logic [63:0]   capture_timestamp;
    logic          overflow_error;
    logic          cmd_error;
    logic [31:0]   status;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q [$];

    adc_capture_core #(
        .AXIS_DATA_WIDTH (256),
        .DEPTH_LOG2      (DL2),
        .INDEX           (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .counter           (counter),
        .s00_axis_tdata    (s00_axis_tdata),
        .s00_axis_tvalid   (s00_axis_tvalid),
        .s00_axis_tready   (s00_axis_tready),
        .cmd_valid         (cmd_valid),
        .cmd_len           (cmd_len),
        .flush             (flush),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .empty             (empty),
        .count             (count),
        .busy              (busy),
        .capture_done      (capture_done),
        .capture_timestamp (capture_timestamp),
        .overflow_error    (overflow_error),
        .cmd_error         (cmd_error),
        .status            (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Drive one beat for the coming edge; queue its halves if it should be stored
    task automatic beat(input logic [255:0] d, input bit keep);
        s00_axis_tdata  = d;
        s00_axis_tvalid = 1'b1;
        if (keep) begin
            exp_q.push_back(d[127:0]);
            exp_q.push_back(d[255:128]);
        end
    endtask

    task automatic start(input logic [63:0] ts, input logic [15:0] len);
        counter   = ts;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [127:0] e;
        check({tag, "_valid"}, 128'(rd_valid), 128'd1);
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb: observed word %0h expected none pending", tag, rd_data);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, rd_data, e);
        end
    endtask

    task automatic drain(input int n, input string tag);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            pop_check(tag);
        end
        rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tready"}, 128'(s00_axis_tready), 128'd0);
        check({tag, "_rd_valid"}, 128'(rd_valid), 128'd0);
        check({tag, "_empty"}, 128'(empty), 128'd1);
        check({tag, "_count"}, 128'(count), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_done"}, 128'(capture_done), 128'd0);
        check({tag, "_ts"}, 128'(capture_timestamp), 128'd0);
        check({tag, "_ovf"}, 128'(overflow_error), 128'd0);
        check({tag, "_cmderr"}, 128'(cmd_error), 128'd0);
        check({tag, "_rd_data"}, rd_data, 128'd0);
        check({tag, "_status"}, 128'(status), 128'h0300_0000);
    endtask

    initial begin
        reset = 1'b1; counter = '0; s00_axis_tdata = '0; s00_axis_tvalid = 1'b0;
        cmd_valid = 1'b0; cmd_len = '0; flush = 1'b0; rd_en = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();
        check("tready_up", 128'(s00_axis_tready), 128'd1);

        // Basic 4-beat capture with timestamp
        start(64'h100, 16'd4);
        check("t1_busy", 128'(busy), 128'd1);
        check("t1_ts", 128'(capture_timestamp), 128'h100);
        for (int i = 0; i < 4; i++) begin
            beat(rand_beat(), 1'b1);
            tick();
            check("t1_empty", 128'(empty), 128'd0);
            check("t1_count", 128'(count), 128'(i + 1));
            check("t1_done", 128'(capture_done), 128'(i == 3));
            check("t1_busy_run", 128'(busy), 128'(i != 3));
        end
        s00_axis_tvalid = 1'b0;
        tick();
        check("t1_done_pulse", 128'(capture_done), 128'd0);
        drain(8, "t1_pop");
        check("t1_empty_after", 128'(empty), 128'd1);

        // Overflow: 6 beats into a 4-entry buffer
        start(64'h200, 16'd6);
        for (int i = 0; i < 6; i++) begin
            beat(rand_beat(), i < 4);
            tick();
            check("t2_ovf", 128'(overflow_error), 128'(i >= 4));
            check("t2_done", 128'(capture_done), 128'(i == 5));
        end
        s00_axis_tvalid = 1'b0;
        check("t2_count", 128'(count), 128'd4);
        check("t2_status", 128'(status), 128'h0302_0004);
        drain(8, "t2_pop");

        // cmd_valid during capture; zero-length command in IDLE
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_flush_ovf", 128'(overflow_error), 128'd0);
        start(64'h210, 16'd3);
        beat(rand_beat(), 1'b1);
        cmd_valid = 1'b1; cmd_len = 16'd9;
        tick();
        cmd_valid = 1'b0;
        check("t3_cmderr", 128'(cmd_error), 128'd1);
        check("t3_busy", 128'(busy), 128'd1);
        beat(rand_beat(), 1'b1);
        tick();
        check("t3_done_early", 128'(capture_done), 128'd0);
        beat(rand_beat(), 1'b1);
        tick();
        s00_axis_tvalid = 1'b0;
        check("t3_done", 128'(capture_done), 128'd1);
        check("t3_ts_kept", 128'(capture_timestamp), 128'h210);
        start(64'h220, 16'd0);
        check("t3_len0_busy", 128'(busy), 128'd0);
        tick();
        check("t3_len0_busy2", 128'(busy), 128'd0);
        check("t3_status", 128'(status), 128'h0304_0003);

        // Full buffer with simultaneous beat and entry-freeing pop
        start(64'h230, 16'd2);
        beat(rand_beat(), 1'b1);
        rd_en = 1'b1;
        tick();
        pop_check("t4_lo");
        check("t4_count4", 128'(count), 128'd4);
        beat(rand_beat(), 1'b0);
        tick();
        pop_check("t4_hi");
        rd_en = 1'b0; s00_axis_tvalid = 1'b0;
        check("t4_count3", 128'(count), 128'd3);
        check("t4_ovf", 128'(overflow_error), 128'd1);
        check("t4_done", 128'(capture_done), 128'd1);
        drain(6, "t4_drain");
        check("t4_empty", 128'(empty), 128'd1);

        // count=1 with simultaneous write and free
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start(64'h240, 16'd2);
        beat(rand_beat(), 1'b1);
        tick();
        s00_axis_tvalid = 1'b0;
        check("t5_count1", 128'(count), 128'd1);
        rd_en = 1'b1;
        tick();
        pop_check("t5_lo");
        beat(rand_beat(), 1'b1);
        tick();
        pop_check("t5_hi");
        rd_en = 1'b0; s00_axis_tvalid = 1'b0;
        check("t5_count_hold", 128'(count), 128'd1);
        check("t5_done", 128'(capture_done), 128'd1);
        drain(2, "t5_drain");
        check("t5_empty", 128'(empty), 128'd1);

        // Pop while empty moves nothing
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t6_rdv_empty", 128'(rd_valid), 128'd0);
        check("t6_count", 128'(count), 128'd0);
        start(64'h250, 16'd1);
        beat(rand_beat(), 1'b1);
        tick();
        s00_axis_tvalid = 1'b0;
        check("t6_done", 128'(capture_done), 128'd1);
        drain(2, "t6_pop");

        // Flush mid-capture
        start(64'h300, 16'd5);
        beat(rand_beat(), 1'b0);
        tick();
        beat(rand_beat(), 1'b0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; s00_axis_tvalid = 1'b0;
        check("t7_cmderr", 128'(cmd_error), 128'd1);
        check("t7_count2", 128'(count), 128'd2);
        counter = 64'h999;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t7_busy", 128'(busy), 128'd0);
        check("t7_empty", 128'(empty), 128'd1);
        check("t7_count", 128'(count), 128'd0);
        check("t7_cmderr_clr", 128'(cmd_error), 128'd0);
        check("t7_ts", 128'(capture_timestamp), 128'h300);
        beat(rand_beat(), 1'b0);
        tick();
        s00_axis_tvalid = 1'b0;
        check("t7_idle_beat", 128'(count), 128'd0);
        check("t7_idle_tready", 128'(s00_axis_tready), 128'd1);

        // Asynchronous reset mid-capture
        start(64'h400, 16'd5);
        beat(rand_beat(), 1'b0);
        tick();
        beat(rand_beat(), 1'b0);
        tick();
        check("t8_count2", 128'(count), 128'd2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t8_async");
        tick();
        check("t8_done_rst", 128'(capture_done), 128'd0);
        reset = 1'b0;
        s00_axis_tvalid = 1'b0;
        tick();
        check("t8_done_after", 128'(capture_done), 128'd0);
        check("t8_busy_after", 128'(busy), 128'd0);
        check("t8_count_after", 128'(count), 128'd0);

        check("sb_leftover", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_core.md
# adc_capture_core

Timestamped capture engine for one RFDC ADC channel, the receive-side counterpart of the DAC controller path. A capture command from the RTO timing core arms the block. It then accepts a programmed number of 256-bit beats from the RFDC ADC AXI-Stream master and buffers them. It presents the data as 128-bit words to the AXI read path, along with the global counter value latched at capture start.

## Interface
- AXIS_DATA_WIDTH, 256, ADC stream beat width; fixed at 2 × 128.
- DEPTH_LOG2, 10, log2 of the buffer depth in 256-bit entries.
- INDEX, 0, channel index; reported in `status[31:24]`.

Ports:
- clk  in  1  system clock (s_axi_aclk domain; the ADC stream is already in this domain).
- reset  in  1  asynchronous, active-high; clears all state.
- counter  in  64  global timestamp from TimeController.
- s00_axis_tdata  in  256  ADC samples.
- s00_axis_tvalid  in  1  ADC beat valid.
- s00_axis_tready  out  1  ready; 0 in reset, 1 otherwise.
- cmd_valid  in  1  one-cycle capture start (RTO counter_matched).
- cmd_len  in  16  beats to capture; sampled with cmd_valid.
- flush  in  1  synchronous clear of the buffer, the FSM and the error flags.
- rd_en  in  1  pop one 128-bit word.
- rd_data  out  128  popped word.
- rd_valid  out  1  rd_data valid, one cycle after an accepted rd_en.
- empty  out  1  no 128-bit word available.
- count  out  DEPTH_LOG2+1  occupied 256-bit entries.
- busy  out  1  FSM is in CAPTURE.
- capture_done  out  1  one-cycle pulse at the end of a capture.
- capture_timestamp  out  64  counter value at the accepted cmd_valid.
- overflow_error  out  1  sticky; a beat was dropped because the buffer was full.
- cmd_error  out  1  sticky; cmd_valid arrived while busy.
- status  out  32  {INDEX[7:0], 5'b0, cmd_error, overflow_error, busy, count zero-extended to 16}.

## Operation
- FSM states are IDLE and CAPTURE.
- IDLE → CAPTURE on cmd_valid with cmd_len≠0. On that transition:
  - latch `capture_timestamp <= counter` and `remaining <= cmd_len`.
- cmd_valid with cmd_len=0 is ignored: no state change, no error.
- In CAPTURE, a beat is consumed on tvalid&&tready.
  - If count<2^DEPTH_LOG2, write the beat and increment count.
  - Otherwise drop the beat and set overflow_error. A dropped beat still counts toward `remaining`.
  - Each consumed beat decrements `remaining`. The beat that takes remaining from 1 to 0 returns the FSM to IDLE and pulses capture_done in the next cycle.
- Beats arriving in IDLE are accepted and discarded; tready stays 1, since the RFDC stream cannot be back-pressured.
- cmd_valid in CAPTURE is ignored and sets cmd_error; the current capture continues.
- Read side:
  - Each entry is read as two words: low half [127:0] first, then high half [255:128].
  - A half-select bit toggles on every pop. The entry is freed, and count decremented, when the high half is popped.
  - rd_en while empty is ignored: rd_valid stays 0 and no pointer moves.
- Full and empty use the count value at the start of the cycle:
  - A simultaneous write and entry-freeing read when full drops the write.
  - A simultaneous write and read when count=1 leaves count=1.
- Pointers wrap modulo 2^DEPTH_LOG2.
- flush takes priority over every other input in its cycle. It clears the pointers, count, half-select, remaining, FSM (to IDLE) and both error flags. It leaves capture_timestamp unchanged.

## Timing
- Reset values:
  - tready=0, rd_valid=0, empty=1, count=0, busy=0, capture_done=0.
  - capture_timestamp=0, errors=0, rd_data=0.
- busy rises the cycle after cmd_valid.
- A beat written in cycle N deasserts empty in N+1.
- rd_en in cycle N: rd_data and rd_valid are registered in N+1.
- Back-to-back rd_en sustains one word per cycle.
- Reset asserted mid-capture aborts immediately. Buffered data is lost and no capture_done is issued.

## Structure
- Shared package `adc_capture_pkg` holds:
  - the `capture_state_e` enum (IDLE, CAPTURE);
  - the STATUS field offset constants;
  - the beat-half width constant 128.
- One sub-module, `capture_buffer`: a 256-bit-wide simple dual-port RAM with registered read, inferred as BRAM. The FSM, pointers and half-select stay in the top level.

## Test plan
- Reset, then cmd_len=4 at counter=0x100 with 4 continuous beats → capture_timestamp=0x100, count=4, capture_done one cycle after the 4th beat, then 8 pops return low then high halves in order.
- DEPTH_LOG2=2, cmd_len=6 → count=4, overflow_error=1, the last 2 beats dropped, capture_done still after the 6th beat.
- cmd_valid during CAPTURE → cmd_error=1, original remaining unaffected; cmd_len=0 in IDLE → busy stays 0.
- Full buffer with a simultaneous beat and high-half pop → count goes 4→3, beat dropped, overflow_error=1; at count=1, simultaneous write and free → count stays 1.
- rd_en while empty → rd_valid=0, pointers unchanged; flush mid-capture → busy=0, empty=1, errors cleared, capture_timestamp retained.
- Reset asserted mid-capture after 2 of 5 beats → all outputs at reset values asynchronously, no capture_done pulse.
